// File: rtl/audio_ram_sequencer.sv
// Streams recorded audio samples into the DDR2 wrapper and plays them back in order.
// A small FIFO absorbs samples while the wrapper is busy (rdy low).
module audio_ram_sequencer #(
    parameter int ADDR_W  = 26,
    parameter int DATA_W  = 8,
    parameter int FIFO_AW = 2
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              record,
    input  logic              play,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              sample_req,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_out_valid,
    output logic              recording,
    output logic              playing,
    output logic              overflow,
    output logic              underrun,
    output logic [ADDR_W:0]   rec_len,
    output logic              play_done,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_in,
    output logic              write_enable,
    output logic              read_request,
    output logic              read_ack,
    input  logic [DATA_W-1:0] data_out,
    input  logic              rdy,
    input  logic              rd_data_pres,
    input  logic [ADDR_W-1:0] max_ram_address
);

    typedef enum logic [2:0] {IDLE, REC, REC_DRAIN, PLAY_WAIT, PLAY_REQ, PLAY_DATA} state_t;

    state_t              state;
    logic                rec_q, play_q, rec_hold, play_hold;
    logic                rec_ev, play_ev;
    logic [DATA_W-1:0]   fifo_mem [2**FIFO_AW];
    logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
    logic [FIFO_AW:0]    count;
    logic                fifo_empty, fifo_full;
    logic                push, pop, sample_drop;
    logic                ram_full, pending, take, in_play;
    logic [ADDR_W-1:0]   rd_addr, wr_addr;

    // Edges seen while rdy is low are held until the FSM can act on them.
    assign rec_ev      = record & ((record & ~rec_q) | rec_hold);
    assign play_ev     = play & ((play & ~play_q) | play_hold);

    assign fifo_empty  = (count == '0);
    assign fifo_full   = count[FIFO_AW];
    assign pop         = rdy && (state == REC || state == REC_DRAIN) && !fifo_empty;
    assign push        = (state == REC) && sample_valid && !ram_full && (!fifo_full || pop);
    assign sample_drop = (state == REC) && sample_valid && !push;

    // The write address always equals the number of samples stored so far.
    assign wr_addr     = rec_len[ADDR_W-1:0];
    assign in_play     = (state == PLAY_WAIT || state == PLAY_REQ || state == PLAY_DATA);
    assign take        = rdy && (state == PLAY_WAIT) && pending;

    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr] <= sample_in;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state            <= IDLE;
            rec_q            <= 1'b0;
            play_q           <= 1'b0;
            rec_hold         <= 1'b0;
            play_hold        <= 1'b0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            ram_full         <= 1'b0;
            pending          <= 1'b0;
            rd_addr          <= '0;
            sample_out       <= '0;
            sample_out_valid <= 1'b0;
            recording        <= 1'b0;
            playing          <= 1'b0;
            overflow         <= 1'b0;
            underrun         <= 1'b0;
            rec_len          <= '0;
            play_done        <= 1'b0;
            address          <= '0;
            data_in          <= '0;
            write_enable     <= 1'b0;
            read_request     <= 1'b0;
            read_ack         <= 1'b0;
        end else begin
            write_enable     <= 1'b0;
            read_request     <= 1'b0;
            read_ack         <= 1'b0;
            sample_out_valid <= 1'b0;
            play_done        <= 1'b0;
            rec_q            <= record;
            play_q           <= play;
            rec_hold         <= !rdy && rec_ev;
            play_hold        <= !rdy && play_ev;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (sample_drop) overflow <= 1'b1;

            if (in_play && sample_req) begin
                pending <= 1'b1;
                if (pending && !take) underrun <= 1'b1;
            end else if (take) begin
                pending <= 1'b0;
            end

            // Once the last RAM address is written, remaining FIFO entries are discarded.
            if (pop) begin
                if (!ram_full) begin
                    write_enable <= 1'b1;
                    address      <= wr_addr;
                    data_in      <= fifo_mem[rd_ptr];
                    rec_len      <= rec_len + 1'b1;
                    if (wr_addr == max_ram_address) ram_full <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end

            if (rdy) begin
                case (state)
                    IDLE: begin
                        if (rec_ev) begin
                            state     <= REC;
                            recording <= 1'b1;
                            rec_len   <= '0;
                            ram_full  <= 1'b0;
                            overflow  <= 1'b0;
                            wr_ptr    <= '0;
                            rd_ptr    <= '0;
                            count     <= '0;
                        end else if (play_ev && !record) begin
                            if (rec_len == '0) begin
                                play_done <= 1'b1;
                            end else begin
                                state    <= PLAY_WAIT;
                                playing  <= 1'b1;
                                rd_addr  <= '0;
                                pending  <= 1'b0;
                                underrun <= 1'b0;
                            end
                        end
                    end
                    REC: if (!record) state <= REC_DRAIN;
                    REC_DRAIN: begin
                        if (fifo_empty) begin
                            state     <= IDLE;
                            recording <= 1'b0;
                        end
                    end
                    PLAY_WAIT: begin
                        if (pending) begin
                            address      <= rd_addr;
                            read_request <= 1'b1;
                            state        <= PLAY_REQ;
                        end else if (!play) begin
                            state   <= IDLE;
                            playing <= 1'b0;
                        end
                    end
                    PLAY_REQ: state <= PLAY_DATA;
                    PLAY_DATA: begin
                        if (rd_data_pres) begin
                            sample_out       <= data_out;
                            sample_out_valid <= 1'b1;
                            read_ack         <= 1'b1;
                            if (!play) begin
                                state   <= IDLE;
                                playing <= 1'b0;
                            end else if ({1'b0, rd_addr} == rec_len - 1'b1) begin
                                play_done <= 1'b1;
                                state     <= IDLE;
                                playing   <= 1'b0;
                            end else begin
                                rd_addr <= rd_addr + 1'b1;
                                state   <= PLAY_WAIT;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_audio_ram_sequencer.sv
// Directed bench for audio_ram_sequencer: scoreboard queues for RAM writes and
// playback samples, checked by a monitor against a 3-cycle-latency wrapper model.
module tb_audio_ram_sequencer;

    logic        CLK = 1'b0;
    logic        reset, record, play, sample_valid, sample_req;
    logic [7:0]  sample_in;
    logic [7:0]  sample_out;
    logic        sample_out_valid, recording, playing, overflow, underrun, play_done;
    logic [26:0] rec_len;
    logic [25:0] address;
    logic [7:0]  data_in;
    logic        write_enable, read_request, read_ack;
    logic [7:0]  data_out;
    logic        rdy, rd_data_pres;
    logic [25:0] max_ram_address;

    audio_ram_sequencer dut (
        .CLK(CLK), .reset(reset), .record(record), .play(play),
        .sample_in(sample_in), .sample_valid(sample_valid), .sample_req(sample_req),
        .sample_out(sample_out), .sample_out_valid(sample_out_valid),
        .recording(recording), .playing(playing), .overflow(overflow), .underrun(underrun),
        .rec_len(rec_len), .play_done(play_done), .address(address), .data_in(data_in),
        .write_enable(write_enable), .read_request(read_request), .read_ack(read_ack),
        .data_out(data_out), .rdy(rdy), .rd_data_pres(rd_data_pres),
        .max_ram_address(max_ram_address)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          fails  = 0;
    int          n_done = 0;
    int          n_reads = 0;
    logic [33:0] wq[$];
    logic [7:0]  sq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Wrapper model: captures writes, answers reads 3 cycles later and holds
    // rd_data_pres until read_ack.
    logic [7:0] mem [16];
    initial begin
        int         cnt;
        logic [7:0] rdata;
        cnt = 0;
        rdata = '0;
        rd_data_pres = 1'b0;
        data_out = '0;
        forever begin
            @(negedge CLK);
            if (reset) begin
                cnt = 0;
                rd_data_pres = 1'b0;
            end else begin
                if (write_enable) mem[address[3:0]] = data_in;
                if (read_ack) rd_data_pres = 1'b0;
                if (read_request) begin
                    rdata = mem[address[3:0]];
                    cnt = 3;
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        data_out = rdata;
                        rd_data_pres = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: every DUT write or playback sample is matched against the queues.
    initial begin
        logic [33:0] w;
        logic [7:0]  s;
        forever begin
            @(negedge CLK);
            if (write_enable) begin
                if (wq.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected none", address, data_in);
                end else begin
                    w = wq.pop_front();
                    check("wr_addr", 32'(address), 32'(w[33:8]));
                    check("wr_data", 32'(data_in), 32'(w[7:0]));
                end
            end
            if (sample_out_valid) begin
                if (sq.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL unexpected_sample: got %0h expected none", sample_out);
                end else begin
                    s = sq.pop_front();
                    check("sample_out", 32'(sample_out), 32'(s));
                    check("read_ack_with_valid", 32'(read_ack), 32'd1);
                end
            end
            if (play_done) n_done++;
            if (read_request) n_reads++;
        end
    end

    task automatic wait_read_request();
        int t;
        t = 0;
        while (!read_request && t < 20) begin
            tick(1);
            t++;
        end
        check("read_request_seen", 32'(read_request), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, r0;
        reset = 1'b1; record = 1'b0; play = 1'b0; sample_valid = 1'b0; sample_req = 1'b0;
        sample_in = '0; rdy = 1'b1; max_ram_address = 26'h3FFFFFF;
        tick(3);
        check("rst_outputs", 32'({write_enable, read_request, read_ack, sample_out_valid,
                                  recording, playing, overflow, underrun, play_done}), 32'd0);
        check("rst_rec_len", 32'(rec_len), 32'd0);
        check("rst_address", 32'(address), 32'd0);
        check("rst_data", 32'({data_in, sample_out}), 32'd0);
        reset = 1'b0;
        tick(2);

        // Record five samples on consecutive cycles.
        record = 1'b1;
        tick(1);
        check("recording_high", 32'(recording), 32'd1);
        for (int i = 0; i < 5; i++) begin
            sample_in = 8'(8'h11 * (i + 1));
            sample_valid = 1'b1;
            wq.push_back({26'(i), sample_in});
            tick(1);
        end
        sample_valid = 1'b0;
        record = 1'b0;
        tick(4);
        check("t1_rec_len", 32'(rec_len), 32'd5);
        check("t1_overflow", 32'(overflow), 32'd0);
        check("t1_recording_low", 32'(recording), 32'd0);
        check("t1_writes_done", 32'(wq.size()), 32'd0);

        // Play back with a request every 20 cycles.
        d0 = n_done;
        play = 1'b1;
        tick(2);
        check("t2_playing", 32'(playing), 32'd1);
        for (int i = 0; i < 5; i++) begin
            sq.push_back(8'(8'h11 * (i + 1)));
            sample_req = 1'b1;
            tick(1);
            sample_req = 1'b0;
            tick(19);
        end
        check("t2_play_done_count", 32'(n_done - d0), 32'd1);
        check("t2_playing_low", 32'(playing), 32'd0);
        check("t2_samples_done", 32'(sq.size()), 32'd0);
        check("t2_underrun", 32'(underrun), 32'd0);
        play = 1'b0;
        tick(2);

        // Two back-to-back requests while a read is outstanding.
        play = 1'b1;
        tick(2);
        r0 = n_reads;
        sq.push_back(8'h11);
        sample_req = 1'b1;
        tick(1);
        sample_req = 1'b0;
        wait_read_request();
        tick(1);
        sq.push_back(8'h22);
        sample_req = 1'b1;
        tick(2);
        sample_req = 1'b0;
        tick(15);
        check("t3_underrun", 32'(underrun), 32'd1);
        check("t3_reads", 32'(n_reads - r0), 32'd2);
        check("t3_samples_done", 32'(sq.size()), 32'd0);
        play = 1'b0;
        tick(3);
        check("t3_playing_low", 32'(playing), 32'd0);

        // Wrapper busy while six samples arrive: FIFO keeps four.
        record = 1'b1;
        tick(2);
        rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sample_in = 8'(8'hA0 + i);
            sample_valid = 1'b1;
            if (i < 4) wq.push_back({26'(i), sample_in});
            tick(1);
        end
        sample_valid = 1'b0;
        tick(4);
        check("t4_no_write_while_busy", 32'(rec_len), 32'd0);
        rdy = 1'b1;
        tick(6);
        record = 1'b0;
        tick(4);
        check("t4_rec_len", 32'(rec_len), 32'd4);
        check("t4_overflow", 32'(overflow), 32'd1);
        check("t4_writes_done", 32'(wq.size()), 32'd0);

        // RAM limited to three locations.
        max_ram_address = 26'd2;
        record = 1'b1;
        tick(1);
        for (int i = 0; i < 5; i++) begin
            sample_in = 8'(8'hB0 + i);
            sample_valid = 1'b1;
            if (i < 3) wq.push_back({26'(i), sample_in});
            tick(1);
        end
        sample_valid = 1'b0;
        record = 1'b0;
        tick(5);
        check("t5_rec_len", 32'(rec_len), 32'd3);
        check("t5_overflow", 32'(overflow), 32'd1);
        check("t5_writes_done", 32'(wq.size()), 32'd0);
        check("t5_recording_low", 32'(recording), 32'd0);

        // Reset while a read is outstanding.
        play = 1'b1;
        tick(2);
        sample_req = 1'b1;
        tick(1);
        sample_req = 1'b0;
        wait_read_request();
        tick(1);
        reset = 1'b1;
        tick(1);
        check("t6_rst_outputs", 32'({write_enable, read_request, read_ack, sample_out_valid,
                                     recording, playing, overflow, underrun, play_done}), 32'd0);
        check("t6_rst_rec_len", 32'(rec_len), 32'd0);
        check("t6_rst_sample_out", 32'(sample_out), 32'd0);
        check("t6_rst_address", 32'(address), 32'd0);
        reset = 1'b0;
        play = 1'b0;
        tick(6);
        d0 = n_done;
        r0 = n_reads;
        play = 1'b1;
        tick(3);
        check("t6_play_done_only", 32'(n_done - d0), 32'd1);
        check("t6_not_playing", 32'(playing), 32'd0);
        check("t6_no_read", 32'(n_reads - r0), 32'd0);
        play = 1'b0;
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
